load_store_unit: RTL and testbench
==================================

Name: load_store_unit

Overview:
- Sits between the execute stage and the data memory / peripheral bus. It sits directly upstream of the data memory and consumes its read data.
- Converts RISC-V load/store requests (LB/LH/LW/LBU/LHU/SB/SH/SW) into byte-masked word accesses, and decodes each address as data memory, peripheral, or fault.
- Runs the handshake to the slow peripheral bus (UART, 7-seg, timer) and holds the pipeline stalled while it waits.
- Aligns and sign-extends returned load data into a registered result.

Parameters:
- MEM_WORDS, 512, data memory depth in 32-bit words; legal memory addresses are 0 .. MEM_WORDS*4-1.
- PERIPH_BASE, 32'h8000_0000, first peripheral address; addr >= PERIPH_BASE is a peripheral access.
- TIMEOUT, 255, maximum number of PERIPH_WAIT cycles before a bus fault.

Ports:
- clk  in  1  clock.
- reset  in  1  asynchronous, active-high reset.
- ls_valid  in  1  execute stage presents a memory operation.
- is_load  in  1  operation is a load.
- is_store  in  1  operation is a store.
- funct3  in  3  RISC-V width/sign code.
- addr  in  32  byte address.
- store_data  in  32  unaligned store operand.
- mem_addr  out  32  word-aligned address (addr & ~3) to data memory.
- mem_wdata  out  32  lane-replicated write data.
- mem_wr_en  out  1  ACTIVE-LOW write strobe.
- mem_rd_en  out  1  active-high read strobe.
- mem_chip_select  out  1  0 = data memory selected, 1 = not selected.
- mem_mask  out  4  byte-lane enables.
- mem_rdata  in  32  memory word; updates on the falling edge of the request cycle.
- per_req  out  1  peripheral request; held until ack or timeout.
- per_we  out  1  peripheral write.
- per_addr  out  32  word-aligned peripheral address.
- per_wdata  out  32  lane-replicated write data.
- per_mask  out  4  byte-lane enables.
- per_ack  in  1  peripheral completion, one-cycle pulse.
- per_rdata  in  32  peripheral read word, valid with per_ack.
- load_data  out  32  aligned, extended load result.
- load_valid  out  1  one-cycle pulse marking load_data valid.
- lsu_stall  out  1  freeze upstream pipeline.
- access_fault  out  1  one-cycle pulse for a misaligned, illegal or timed-out access.

Behaviour:
- Reset (async): FSM = IDLE, per_req = 0, load_data = 0, load_valid = 0, access_fault = 0, timeout counter = 0.
- Reset defaults for the combinational memory outputs: mem_wr_en = 1, mem_rd_en = 0, mem_chip_select = 1, mem_mask = 0.
- Reset asserted mid-wait: per_req drops immediately and the pending access is abandoned.

Request legality:
- Legal funct3, loads: 0 LB, 1 LH, 2 LW, 4 LBU, 5 LHU.
- Legal funct3, stores: 0, 1, 2.
- A request is legal only if it is exactly one of load/store, uses a legal funct3, and is aligned.
- Aligned means: halfword has addr[0] = 0; word has addr[1:0] = 0.
- addr in MEM_WORDS*4 .. PERIPH_BASE-1 is a fault.
- Any illegal request: no access is issued (memory defaults held, per_req = 0), and access_fault pulses the next cycle. load_valid stays 0.

Store lanes (off = addr[1:0]):
- SB: mask = 1 << off; wdata = byte replicated x4.
- SH: mask = 0011 when off = 0, 1100 when off = 2; wdata = halfword replicated x2.
- SW: mask = 1111.
- Loads use the same mask; mem_rd_en = 1 only for loads.

Memory path (IDLE, legal, addr < MEM_WORDS*4):
- Outputs are combinational in request cycle N: mem_chip_select = 0, plus mem_wr_en = 0 for a store or mem_rd_en = 1 for a load.
- The LSU captures mem_rdata at the rising edge ending cycle N, extracting the lane at off: sign-extend for LB/LH, zero-extend for LBU/LHU.
- load_data is valid in cycle N+1 with load_valid = 1 for one cycle.
- lsu_stall = 0 throughout.

Peripheral path, FSM IDLE -> PERIPH_WAIT -> IDLE:
- Request cycle: lsu_stall = 1 combinationally; per_* outputs are registered, so per_req rises at the next edge.
- PERIPH_WAIT: per_req is held with stable per_addr, per_we, per_wdata and per_mask; the counter increments each cycle.
- lsu_stall = !per_ack in PERIPH_WAIT.
- On per_ack: per_req drops; for a load, the LSU captures and aligns per_rdata and pulses load_valid the next cycle; FSM returns to IDLE. The stalled instruction leaves at that same edge.
- A per_ack seen in IDLE is ignored.
- Counter reaching TIMEOUT with no ack: per_req drops, lsu_stall drops, access_fault pulses, load_data = 0, FSM returns to IDLE.

Back-to-back accesses:
- Memory accesses may issue every cycle.
- A new request while load_valid is high is permitted.

Test Plan:
- LB at addr 0x0000_0007, word 0x80FF_1234 -> lane 3 selected, load_data = 0xFFFF_FF80, load_valid high exactly in cycle N+1.
- SH store_data 0x0000_ABCD at addr 0x0000_0012 -> mem_mask = 1100, mem_wdata = 0xABCD_ABCD, mem_wr_en = 0, mem_chip_select = 0, mem_addr = 0x10.
- LW at addr 0x0000_0006 -> no access (mem_rd_en = 0), access_fault pulses once, lsu_stall = 0; a load of 0x0000_0800 (MEM_WORDS = 512, the first address past memory) also faults.
- Peripheral LHU at 0x8000_0002, per_ack after 3 wait cycles with per_rdata 0x9876_0000 -> per_req high for 3 cycles, lsu_stall high until the ack cycle, load_data = 0x0000_9876.
- Peripheral store with no ack -> per_req drops after 255 wait cycles, access_fault pulses, FSM returns to IDLE, the next memory load completes normally.
- Reset asserted during PERIPH_WAIT -> per_req, lsu_stall and load_valid go to 0 immediately; a later per_ack produces no load_valid.

Source files
------------

// File: rtl/load_store_unit.sv
// rtl/load_store_unit.sv - RISC-V load/store unit with data memory and peripheral bus paths
//
// Ports:
//   clk, reset          clock, asynchronous active-high reset
//   ls_valid, is_load,  execute-stage request: valid, direction,
//   is_store, funct3,   RISC-V width/sign code, byte address and
//   addr, store_data    unaligned store operand
//   mem_*               combinational word access to the data memory
//                       (mem_wr_en active low, mem_chip_select active low);
//                       mem_rdata is sampled at the end of the request cycle
//   per_*               registered request/ack handshake to the peripheral bus
//   load_data/valid     registered aligned load result, one-cycle valid pulse
//   lsu_stall           freezes upstream while a peripheral access is pending
//   access_fault        one-cycle pulse for illegal or timed-out accesses
module load_store_unit #(
  parameter int          MEM_WORDS   = 512,
  parameter logic [31:0] PERIPH_BASE = 32'h8000_0000,
  parameter int          TIMEOUT     = 255
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        ls_valid,
  input  logic        is_load,
  input  logic        is_store,
  input  logic [2:0]  funct3,
  input  logic [31:0] addr,
  input  logic [31:0] store_data,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic        mem_wr_en,
  output logic        mem_rd_en,
  output logic        mem_chip_select,
  output logic [3:0]  mem_mask,
  input  logic [31:0] mem_rdata,
  output logic        per_req,
  output logic        per_we,
  output logic [31:0] per_addr,
  output logic [31:0] per_wdata,
  output logic [3:0]  per_mask,
  input  logic        per_ack,
  input  logic [31:0] per_rdata,
  output logic [31:0] load_data,
  output logic        load_valid,
  output logic        lsu_stall,
  output logic        access_fault
);

  localparam logic [0:0]  IDLE        = 1'b0;
  localparam logic [0:0]  PERIPH_WAIT = 1'b1;
  localparam int          CW          = $clog2(TIMEOUT + 1);
  localparam logic [31:0] MEM_LIMIT   = 32'(MEM_WORDS * 4);

  logic [0:0]    state;
  logic [CW-1:0] wait_cnt;
  logic [2:0]    per_f3;
  logic [1:0]    per_off;

  logic [1:0]  off;
  logic        op_ok, f3_ok, aligned, in_mem, in_per, legal;
  logic        req, mem_go, per_go, bad_req, timeout_hit;
  logic [3:0]  lane_mask;
  logic [31:0] lane_wdata;

  // Shift the addressed lane down to bit 0, then sign- or zero-extend.
  function automatic logic [31:0] align_load(input logic [31:0] word,
                                             input logic [1:0]  lane,
                                             input logic [2:0]  f3);
    logic [31:0] sh;
    sh = word >> {lane, 3'b000};
    case (f3)
      3'd0:    return {{24{sh[7]}}, sh[7:0]};
      3'd1:    return {{16{sh[15]}}, sh[15:0]};
      3'd4:    return {24'd0, sh[7:0]};
      3'd5:    return {16'd0, sh[15:0]};
      default: return word;
    endcase
  endfunction

  always_comb begin
    off     = addr[1:0];
    op_ok   = is_load ^ is_store;
    f3_ok   = is_load ? (funct3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5})
                      : (funct3 inside {3'd0, 3'd1, 3'd2});
    case (funct3[1:0])
      2'd0:    aligned = 1'b1;
      2'd1:    aligned = ~addr[0];
      2'd2:    aligned = (addr[1:0] == 2'b00);
      default: aligned = 1'b0;
    endcase
    in_mem  = (addr < MEM_LIMIT);
    in_per  = (addr >= PERIPH_BASE);
    legal   = op_ok && f3_ok && aligned && (in_mem || in_per);

    case (funct3[1:0])
      2'd0:    lane_mask = 4'b0001 << off;
      2'd1:    lane_mask = off[1] ? 4'b1100 : 4'b0011;
      default: lane_mask = 4'b1111;
    endcase
    case (funct3[1:0])
      2'd0:    lane_wdata = {4{store_data[7:0]}};
      2'd1:    lane_wdata = {2{store_data[15:0]}};
      default: lane_wdata = store_data;
    endcase

    // New requests are only accepted in IDLE; in PERIPH_WAIT the inputs
    // still show the stalled instruction and must not be re-issued.
    req     = ls_valid && (state == IDLE);
    mem_go  = req && legal && in_mem;
    per_go  = req && legal && in_per;
    bad_req = req && !legal;

    timeout_hit = (state == PERIPH_WAIT) && (wait_cnt == CW'(TIMEOUT - 1));

    mem_addr        = {addr[31:2], 2'b00};
    mem_wdata       = lane_wdata;
    mem_wr_en       = 1'b1;
    mem_rd_en       = 1'b0;
    mem_chip_select = 1'b1;
    mem_mask        = 4'b0000;
    if (mem_go) begin
      mem_chip_select = 1'b0;
      mem_mask        = lane_mask;
      mem_wr_en       = ~is_store;
      mem_rd_en       = is_load;
    end

    // Stall releases in the cycle the wait ends (ack or last timeout cycle)
    // so the held instruction retires on the same edge the FSM leaves.
    lsu_stall = per_go ||
                ((state == PERIPH_WAIT) && !per_ack && !timeout_hit);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state        <= IDLE;
      wait_cnt     <= '0;
      per_req      <= 1'b0;
      per_we       <= 1'b0;
      per_addr     <= 32'd0;
      per_wdata    <= 32'd0;
      per_mask     <= 4'd0;
      per_f3       <= 3'd0;
      per_off      <= 2'd0;
      load_data    <= 32'd0;
      load_valid   <= 1'b0;
      access_fault <= 1'b0;
    end else begin
      load_valid   <= 1'b0;
      access_fault <= 1'b0;
      case (state)
        IDLE: begin
          if (mem_go && is_load) begin
            load_data  <= align_load(mem_rdata, off, funct3);
            load_valid <= 1'b1;
          end
          if (per_go) begin
            state     <= PERIPH_WAIT;
            wait_cnt  <= '0;
            per_req   <= 1'b1;
            per_we    <= is_store;
            per_addr  <= {addr[31:2], 2'b00};
            per_wdata <= lane_wdata;
            per_mask  <= lane_mask;
            per_f3    <= funct3;
            per_off   <= off;
          end
          if (bad_req) begin
            access_fault <= 1'b1;
          end
        end
        PERIPH_WAIT: begin
          if (per_ack) begin
            state   <= IDLE;
            per_req <= 1'b0;
            if (!per_we) begin
              load_data  <= align_load(per_rdata, per_off, per_f3);
              load_valid <= 1'b1;
            end
          end else if (timeout_hit) begin
            state        <= IDLE;
            per_req      <= 1'b0;
            access_fault <= 1'b1;
            load_data    <= 32'd0;
          end else begin
            wait_cnt <= wait_cnt + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_load_store_unit.sv
// tb/tb_load_store_unit.sv - scoreboard bench for load_store_unit with byte-level reference model
module tb_load_store_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic        ls_valid, is_load, is_store;
  logic [2:0]  funct3;
  logic [31:0] addr, store_data;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic        mem_wr_en, mem_rd_en, mem_chip_select;
  logic [3:0]  mem_mask;
  logic        per_req, per_we, per_ack;
  logic [31:0] per_addr, per_wdata, per_rdata;
  logic [3:0]  per_mask;
  logic [31:0] load_data;
  logic        load_valid, lsu_stall, access_fault;

  always #5 clk = ~clk;

  load_store_unit #(.MEM_WORDS(512), .PERIPH_BASE(32'h8000_0000), .TIMEOUT(255)) dut (
    .clk(clk), .reset(reset), .ls_valid(ls_valid), .is_load(is_load),
    .is_store(is_store), .funct3(funct3), .addr(addr), .store_data(store_data),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_wr_en(mem_wr_en),
    .mem_rd_en(mem_rd_en), .mem_chip_select(mem_chip_select), .mem_mask(mem_mask),
    .mem_rdata(mem_rdata), .per_req(per_req), .per_we(per_we), .per_addr(per_addr),
    .per_wdata(per_wdata), .per_mask(per_mask), .per_ack(per_ack),
    .per_rdata(per_rdata), .load_data(load_data), .load_valid(load_valid),
    .lsu_stall(lsu_stall), .access_fault(access_fault)
  );

  typedef struct {
    bit          fault;
    bit          zero;
    logic [31:0] data;
    int          cyc;
  } ev_t;

  ev_t         sb[$];
  int          n_checks = 0;
  int          n_fail   = 0;
  int          cyc      = 0;
  logic [31:0] mem [0:511];
  logic [7:0]  ref_bytes [0:2047];
  logic [3:0]  s_mask;
  logic [31:0] s_wdata, s_addr;
  logic        s_wr, s_rd, s_cs, s_stall;

  always @(posedge clk) cyc <= cyc + 1;

  // Physical data memory: written from the DUT strobes, read on the falling edge.
  always @(posedge clk) begin
    if (!reset && !mem_chip_select && !mem_wr_en)
      for (int j = 0; j < 4; j++)
        if (mem_mask[j]) mem[mem_addr[10:2]][8*j +: 8] <= mem_wdata[8*j +: 8];
  end
  always @(negedge clk) mem_rdata = mem[mem_addr[10:2]];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual %h required %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic check1(input string name, input logic act, input logic exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual %b required %b (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic int size_of(input logic [2:0] f3);
    case (f3[1:0])
      2'd0:    return 1;
      2'd1:    return 2;
      2'd2:    return 4;
      default: return 0;
    endcase
  endfunction

  function automatic bit model_legal(input bit ld, input bit st, input logic [2:0] f3,
                                     input logic [31:0] a);
    int n;
    n = size_of(f3);
    if (ld == st) return 0;
    if (n == 0) return 0;
    if (st && f3 > 3'd2) return 0;
    if (ld && !(f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5})) return 0;
    if ((a % n) != 0) return 0;
    return (a < 32'd2048) || (a >= 32'h8000_0000);
  endfunction

  function automatic logic [31:0] extend(input logic [31:0] raw, input int n, input bit sgn);
    longint m, v;
    if (n == 4) return raw;
    m = longint'(1) << (8 * n);
    v = longint'(raw);
    if (sgn && v >= m / 2) v = v - m;
    return v[31:0];
  endfunction

  function automatic logic [3:0] lanes_of(input int n, input int off);
    return 4'(((1 << n) - 1) << off);
  endfunction

  // Expected byte lanes: operand byte i lands in lane off+i.
  function automatic logic [31:0] exp_lanes(input logic [31:0] d, input int n, input int off);
    logic [31:0] r;
    r = 32'd0;
    for (int i = 0; i < n; i++) r[8*(off+i) +: 8] = d[8*i +: 8];
    return r;
  endfunction

  function automatic logic [31:0] keep_lanes(input logic [31:0] w, input logic [3:0] m);
    logic [31:0] r;
    r = 32'd0;
    for (int j = 0; j < 4; j++) if (m[j]) r[8*j +: 8] = w[8*j +: 8];
    return r;
  endfunction

  // Monitor: every result pulse must match the head of the scoreboard.
  always @(negedge clk) begin
    ev_t e;
    if (!reset && (load_valid || access_fault)) begin
      if (sb.size() == 0) begin
        check("unexpected_event", {30'd0, load_valid, access_fault}, 32'd0);
      end else begin
        e = sb.pop_front();
        check1("ev_fault", access_fault, e.fault);
        check1("ev_load_valid", load_valid, !e.fault);
        check("ev_cycle", cyc, e.cyc);
        if (!e.fault || e.zero) check("ev_load_data", load_data, e.data);
      end
    end
  end

  // Memory-path or illegal request; entered and left just after a rising edge.
  task automatic op(input bit ld, input bit st, input logic [2:0] f3,
                    input logic [31:0] a, input logic [31:0] d);
    bit          legal;
    int          n, off;
    logic [3:0]  em;
    logic [31:0] raw;
    ev_t         e;
    legal = model_legal(ld, st, f3, a);
    n     = size_of(f3);
    off   = int'(a[1:0]);
    ls_valid = 1'b1; is_load = ld; is_store = st; funct3 = f3; addr = a; store_data = d;
    per_ack   = ($urandom_range(0, 7) == 0);
    per_rdata = $urandom;
    @(negedge clk);
    s_mask = mem_mask; s_wdata = mem_wdata; s_addr = mem_addr;
    s_wr = mem_wr_en; s_rd = mem_rd_en; s_cs = mem_chip_select; s_stall = lsu_stall;
    check1("mem_stall", lsu_stall, 1'b0);
    if (legal) begin
      em = lanes_of(n, off);
      check1("mem_cs", mem_chip_select, 1'b0);
      check1("mem_rd_en", mem_rd_en, ld);
      check1("mem_wr_en", mem_wr_en, !st);
      check("mem_mask", 32'(mem_mask), 32'(em));
      check("mem_addr", mem_addr, a & 32'hFFFF_FFFC);
      check("mem_wdata_lanes", keep_lanes(mem_wdata, em), exp_lanes(d, n, off));
      if (ld) begin
        raw = 32'd0;
        for (int i = 0; i < n; i++) raw[8*i +: 8] = ref_bytes[a + i];
        e.fault = 0; e.zero = 0; e.data = extend(raw, n, f3 < 3'd4); e.cyc = cyc + 1;
        sb.push_back(e);
      end else begin
        for (int i = 0; i < n; i++) ref_bytes[a + i] = d[8*i +: 8];
      end
    end else begin
      check1("bad_cs", mem_chip_select, 1'b1);
      check1("bad_rd_en", mem_rd_en, 1'b0);
      check1("bad_wr_en", mem_wr_en, 1'b1);
      check("bad_mask", 32'(mem_mask), 32'd0);
      e.fault = 1; e.zero = 0; e.data = 32'd0; e.cyc = cyc + 1;
      sb.push_back(e);
    end
    @(posedge clk); #1;
    ls_valid = 1'b0; per_ack = 1'b0;
  endtask

  // Legal peripheral request; k = wait cycle carrying the ack, 0 = never ack.
  task automatic per_op(input bit ld, input bit st, input logic [2:0] f3,
                        input logic [31:0] a, input logic [31:0] d,
                        input int k, input logic [31:0] rd);
    int          n, off, hi, i;
    bit          done;
    logic [3:0]  em;
    logic [31:0] raw;
    ev_t         e;
    n = size_of(f3); off = int'(a[1:0]); hi = 0; i = 1; done = 0;
    em = lanes_of(n, off);
    ls_valid = 1'b1; is_load = ld; is_store = st; funct3 = f3; addr = a; store_data = d;
    per_ack = 1'b0;
    @(negedge clk);
    check1("per_issue_stall", lsu_stall, 1'b1);
    check1("per_issue_cs", mem_chip_select, 1'b1);
    check1("per_issue_req", per_req, 1'b0);
    @(posedge clk); #1;
    while (!done) begin
      if (per_req) hi++;
      check("per_addr", per_addr, a & 32'hFFFF_FFFC);
      check1("per_we", per_we, st);
      check("per_mask", 32'(per_mask), 32'(em));
      check("per_wdata_lanes", keep_lanes(per_wdata, em), exp_lanes(d, n, off));
      done = (k != 0) ? (i == k) : (i == 255);
      if (k != 0 && done) begin
        per_ack = 1'b1; per_rdata = rd;
      end else begin
        per_rdata = $urandom;
      end
      @(negedge clk);
      check1("per_wait_stall", lsu_stall, !done);
      if (done && k == 0) begin
        e.fault = 1; e.zero = 1; e.data = 32'd0; e.cyc = cyc + 1;
        sb.push_back(e);
      end else if (done && ld) begin
        raw = (rd >> (8 * off)) & 32'((longint'(1) << (8 * n)) - 1);
        e.fault = 0; e.zero = 0; e.data = extend(raw, n, f3 < 3'd4); e.cyc = cyc + 1;
        sb.push_back(e);
      end
      @(posedge clk); #1;
      per_ack = 1'b0;
      i++;
    end
    ls_valid = 1'b0;
    check1("per_req_drop", per_req, 1'b0);
    check("per_req_cycles", hi, (k != 0) ? k : 255);
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] w, a, d;
    logic [2:0]  f3;
    bit          ld, st;
    int          r;
    reset = 1'b1; ls_valid = 1'b0; is_load = 1'b0; is_store = 1'b0; funct3 = 3'd0;
    addr = 32'd0; store_data = 32'd0; per_ack = 1'b0; per_rdata = 32'd0;
    for (int wi = 0; wi < 512; wi++) begin
      w = (wi == 1) ? 32'h80FF_1234 : $urandom;
      mem[wi] = w;
      for (int b = 0; b < 4; b++) ref_bytes[wi*4 + b] = w[8*b +: 8];
    end
    repeat (3) @(negedge clk);
    check1("rst_wr_en", mem_wr_en, 1'b1);
    check1("rst_rd_en", mem_rd_en, 1'b0);
    check1("rst_cs", mem_chip_select, 1'b1);
    check("rst_mask", 32'(mem_mask), 32'd0);
    check1("rst_per_req", per_req, 1'b0);
    check("rst_load_data", load_data, 32'd0);
    check1("rst_load_valid", load_valid, 1'b0);
    check1("rst_fault", access_fault, 1'b0);
    check1("rst_stall", lsu_stall, 1'b0);
    reset = 1'b0;
    @(posedge clk); #1;

    // LB lane 3 of 0x80FF1234, valid exactly in N+1
    op(1, 0, 3'd0, 32'h0000_0007, 32'd0);
    @(negedge clk);
    check1("lb_valid_n1", load_valid, 1'b1);
    check("lb_data", load_data, 32'hFFFF_FF80);
    @(negedge clk);
    check1("lb_valid_n2", load_valid, 1'b0);
    @(posedge clk); #1;

    // SH upper half
    op(0, 1, 3'd1, 32'h0000_0012, 32'h0000_ABCD);
    check("sh_mask", 32'(s_mask), 32'h0000_000C);
    check("sh_wdata", s_wdata, 32'hABCD_ABCD);
    check1("sh_wr_en", s_wr, 1'b0);
    check1("sh_cs", s_cs, 1'b0);
    check("sh_addr", s_addr, 32'h0000_0010);
    op(1, 0, 3'd5, 32'h0000_0012, 32'd0);

    // misaligned LW and first address past memory
    op(1, 0, 3'd2, 32'h0000_0006, 32'd0);
    check1("misal_rd_en", s_rd, 1'b0);
    check1("misal_stall", s_stall, 1'b0);
    op(1, 0, 3'd2, 32'h0000_0800, 32'd0);
    check1("hole_rd_en", s_rd, 1'b0);
    @(posedge clk); #1;

    // peripheral LHU with ack in the third wait cycle
    per_op(1, 0, 3'd5, 32'h8000_0002, 32'd0, 3, 32'h9876_0000);
    @(negedge clk);
    check("lhu_per_data", load_data, 32'h0000_9876);
    @(posedge clk); #1;

    // peripheral store timeout, then a normal memory load
    per_op(0, 1, 3'd2, 32'h8000_0004, 32'hDEAD_BEEF, 0, 32'd0);
    op(1, 0, 3'd2, 32'h0000_0020, 32'd0);
    @(posedge clk); #1;

    // reset while waiting on the peripheral
    ls_valid = 1'b1; is_load = 1'b1; is_store = 1'b0; funct3 = 3'd2; addr = 32'h8000_0010;
    @(posedge clk); #1;
    check1("rstw_req_up", per_req, 1'b1);
    @(posedge clk); #2;
    reset = 1'b1; ls_valid = 1'b0;
    #1;
    check1("rstw_per_req", per_req, 1'b0);
    check1("rstw_stall", lsu_stall, 1'b0);
    check1("rstw_load_valid", load_valid, 1'b0);
    @(negedge clk); reset = 1'b0;
    @(posedge clk); #1; per_ack = 1'b1; per_rdata = 32'h1234_5678;
    @(posedge clk); #1; per_ack = 1'b0;
    @(negedge clk);
    check1("rstw_late_ack_lv", load_valid, 1'b0);
    check1("rstw_late_ack_req", per_req, 1'b0);
    @(posedge clk); #1;

    // randomized mix
    for (int t = 0; t < 400; t++) begin
      r = $urandom_range(0, 9);
      if (r == 0)      begin ld = 1; st = 1; end
      else if (r == 1) begin ld = 0; st = 0; end
      else             begin ld = ($urandom_range(0, 1) == 1); st = !ld; end
      if ($urandom_range(0, 4) == 0) f3 = 3'($urandom_range(0, 7));
      else f3 = {ld && ($urandom_range(0, 1) == 1), 2'($urandom_range(0, 2))};
      r = $urandom_range(0, 19);
      if (r == 0)      a = 32'h0000_0800 + $urandom_range(0, 255);
      else if (r == 1) a = 32'h0000_07F8 + $urandom_range(0, 7);
      else if (r < 4)  a = 32'h8000_0000 + $urandom_range(0, 63);
      else             a = $urandom_range(0, 127);
      d = $urandom;
      if (model_legal(ld, st, f3, a) && a >= 32'h8000_0000)
        per_op(ld, st, f3, a, d, $urandom_range(1, 4), $urandom);
      else
        op(ld, st, f3, a, d);
    end

    repeat (3) @(posedge clk);
    #1;
    check("sb_empty", sb.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
